// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Sequencer in front of a 4:1 select mux. It walks the select lines through
// channels 0,1,2,3 and holds each channel for DWELL_CYCLES clocks. It samples
// the mux output SETTLE_CYCLES clocks after each select change, then packs
// the four samples into a frame. It runs one frame at a time, or runs frames
// back to back when continuous is high.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        begin a scan (honoured only when idle)
//   continuous   sampled at the channel-3 end edge; 1 = start next frame
//   mux_out      output of the downstream 4:1 mux
//   s0, s1       mux select (s1:s0 = channel)
//   busy         high while scanning
//   sample_valid one-cycle pulse per captured channel
//   sample_ch    channel of the current sample
//   sample_bit   captured value
//   frame        last complete frame, frame[i] = sample of channel i
//   frame_valid  one-cycle pulse when frame updates
module mux_scan_ctrl #(
  parameter int DWELL_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic       sample_bit,
  output logic [3:0] frame,
  output logic       frame_valid
);

  localparam logic [7:0] LAST_CNT   = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE_CYCLES);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic       frame_valid_q, frame_valid_d;
  logic       sample_valid_q, sample_valid_d;
  logic [1:0] sample_ch_q, sample_ch_d;
  logic       sample_bit_q, sample_bit_d;
  logic       busy_q, busy_d;

  logic sample_now;
  logic dwell_end;
  logic frame_end;

  assign sample_now = (state_q == SCAN) && (cnt_q == SETTLE_CNT);
  assign dwell_end  = (state_q == SCAN) && (cnt_q == LAST_CNT);
  assign frame_end  = dwell_end && (ch_q == 2'd3);

  // State register: every flop in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ch_q           <= '0;
      shadow_q       <= '0;
      frame_q        <= '0;
      frame_valid_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_bit_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ch_q           <= ch_d;
      shadow_q       <= shadow_d;
      frame_q        <= frame_d;
      frame_valid_q  <= frame_valid_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_bit_q   <= sample_bit_d;
      busy_q         <= busy_d;
    end
  end

  // Next state: dwell counter and channel pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        // ch stays 0 in IDLE, so the select lines idle at 00.
        cnt_d = '0;
        ch_d  = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        if (dwell_end) begin
          cnt_d = '0;
          if (ch_q == 2'd3) begin
            ch_d = '0;
            if (!continuous) state_d = IDLE;
          end else begin
            ch_d = ch_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow capture: each bit is loaded only while its own channel is selected.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      assign shadow_d[gi] = (sample_now && (ch_q == 2'(gi))) ? mux_out : shadow_q[gi];
    end
  endgenerate

  // Next values for the registered outputs.
  always_comb begin
    sample_valid_d = sample_now;
    sample_ch_d    = sample_now ? ch_q : sample_ch_q;
    sample_bit_d   = sample_now ? mux_out : sample_bit_q;
    frame_valid_d  = frame_end;
    // shadow_d already holds the channel-3 sample when it falls on the same
    // edge as the end of the frame (SETTLE_CYCLES == DWELL_CYCLES-1).
    frame_d        = frame_end ? shadow_d : frame_q;
    busy_d         = (state_d == SCAN);
  end

  assign s0           = ch_q[0];
  assign s1           = ch_q[1];
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_bit   = sample_bit_q;
  assign frame        = frame_q;
  assign frame_valid  = frame_valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. Three instances cover the default
// timing (A), a dwell of 2 with the settle point on the last dwell cycle (B),
// and a settle point of 2 with a mux output that changes within the dwell (C).
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] d;          // mux model data, bit i = channel i
  logic       start_a, start_b, start_c;
  logic       cont_a, cont_b, cont_c;
  logic       mux_a, mux_b, mux_c;

  logic       s0_a, s1_a, busy_a, sv_a, sb_a, fv_a;
  logic [1:0] sc_a;
  logic [3:0] fr_a;
  logic       s0_b, s1_b, busy_b, sv_b, sb_b, fv_b;
  logic [1:0] sc_b;
  logic [3:0] fr_b;
  logic       s0_c, s1_c, busy_c, sv_c, sb_c, fv_c;
  logic [1:0] sc_c;
  logic [3:0] fr_c;

  logic [3:0] early_c, late_c;

  int n_checks = 0;
  int n_pass   = 0;

  assign mux_a = d[{s1_a, s0_a}];
  assign mux_b = d[{s1_b, s0_b}];

  mux_scan_ctrl #(.DWELL_CYCLES(4), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .mux_out(mux_a),
    .s0(s0_a), .s1(s1_a), .busy(busy_a), .sample_valid(sv_a), .sample_ch(sc_a),
    .sample_bit(sb_a), .frame(fr_a), .frame_valid(fv_a));

  mux_scan_ctrl #(.DWELL_CYCLES(2), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .mux_out(mux_b),
    .s0(s0_b), .s1(s1_b), .busy(busy_b), .sample_valid(sv_b), .sample_ch(sc_b),
    .sample_bit(sb_b), .frame(fr_b), .frame_valid(fv_b));

  mux_scan_ctrl #(.DWELL_CYCLES(4), .SETTLE_CYCLES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .continuous(cont_c), .mux_out(mux_c),
    .s0(s0_c), .s1(s1_c), .busy(busy_c), .sample_valid(sv_c), .sample_ch(sc_c),
    .sample_bit(sb_c), .frame(fr_c), .frame_valid(fv_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_sel"}, {30'd0, s1_a, s0_a}, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_sv"}, sv_a, 0);
    chk({tag, "_sch"}, sc_a, 0);
    chk({tag, "_sbit"}, sb_a, 0);
    chk({tag, "_frame"}, fr_a, 0);
    chk({tag, "_fv"}, fv_a, 0);
  endtask

  // One single-shot frame on instance A; optionally pulse start in cycle 5.
  task automatic run_single_a(input string tag, input logic [3:0] dv,
                              input logic [3:0] exp_f, input bit poke);
    d = dv;
    cont_a = 1'b0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_busy"}, busy_a, 1);
      chk({tag, "_sel"}, {30'd0, s1_a, s0_a}, k / 4);
      chk({tag, "_sv"}, sv_a, (k % 4) == 2);
      if ((k % 4) == 2) begin
        chk({tag, "_sch"}, sc_a, k / 4);
        chk({tag, "_sbit"}, sb_a, dv[k / 4]);
      end
      chk({tag, "_fv_early"}, fv_a, 0);
      start_a = poke && (k == 5);
      tick;
    end
    start_a = 1'b0;
    chk({tag, "_end_busy"}, busy_a, 0);
    chk({tag, "_end_sel"}, {30'd0, s1_a, s0_a}, 0);
    chk({tag, "_end_fv"}, fv_a, 1);
    chk({tag, "_end_frame"}, fr_a, exp_f);
    tick;
    chk({tag, "_post_fv"}, fv_a, 0);
    chk({tag, "_post_frame"}, fr_a, exp_f);
    chk({tag, "_post_busy"}, busy_a, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    d = 4'b0000;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cont_a = 1'b0;  cont_b = 1'b0;  cont_c = 1'b0;
    mux_c = 1'b0;
    early_c = 4'b1001;
    late_c  = 4'b0110;
    tick;
    tick;
    chk_reset_a("rst");
    chk("rst_b_frame", fr_b, 0);
    chk("rst_c_busy", busy_c, 0);
    rst_n = 1'b1;
    tick;

    // 1: single shot, data 0,1,0,1
    run_single_a("s1", 4'b1010, 4'b1010, 1'b0);

    // 2: continuous, two frames 16 cycles apart, busy never drops
    d = 4'b0011;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("s2_busy1", busy_a, 1);
      chk("s2_fv1_early", fv_a, 0);
      tick;
    end
    chk("s2_fv1", fv_a, 1);
    chk("s2_frame1", fr_a, 4'b0011);
    chk("s2_busy_hold", busy_a, 1);
    chk("s2_sel_wrap", {30'd0, s1_a, s0_a}, 0);
    d = 4'b1100;
    tick;
    for (int k = 17; k < 32; k++) begin
      chk("s2_busy2", busy_a, 1);
      chk("s2_fv2_early", fv_a, 0);
      if (k == 24) cont_a = 1'b0;
      tick;
    end
    chk("s2_fv2", fv_a, 1);
    chk("s2_frame2", fr_a, 4'b1100);
    chk("s2_stop_busy", busy_a, 0);
    tick;
    chk("s2_fv2_off", fv_a, 0);

    // 3: start pulsed mid-scan is ignored
    run_single_a("s3", 4'b1010, 4'b1010, 1'b1);

    // 4: reset during channel 2
    d = 4'b0110;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (9) tick;
    chk("s4_in_ch2", {30'd0, s1_a, s0_a}, 2);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_reset_a("s4_rst");
    for (int k = 0; k < 12; k++) begin
      chk("s4_no_fv", fv_a, 0);
      chk("s4_idle_busy", busy_a, 0);
      tick;
    end
    run_single_a("s4_new", 4'b1001, 4'b1001, 1'b0);

    // 5: DWELL=2, SETTLE=1, data 1,0,1,1; channel-3 capture shares the end edge
    d = 4'b1101;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("s5_busy", busy_b, 1);
      chk("s5_sel", {30'd0, s1_b, s0_b}, k / 2);
      chk("s5_sv", sv_b, (k % 2 == 0) && (k > 0));
      if ((k % 2 == 0) && (k > 0)) begin
        chk("s5_sch", sc_b, k / 2 - 1);
        chk("s5_sbit", sb_b, d[k / 2 - 1]);
      end
      chk("s5_fv_early", fv_b, 0);
      tick;
    end
    chk("s5_end_busy", busy_b, 0);
    chk("s5_end_fv", fv_b, 1);
    chk("s5_frame", fr_b, 4'b1101);
    chk("s5_end_sv", sv_b, 1);
    chk("s5_end_sch", sc_b, 3);
    chk("s5_end_sbit", sb_b, 1);
    chk("s5_end_sel", {30'd0, s1_b, s0_b}, 0);
    tick;
    chk("s5_post_sv", sv_b, 0);
    chk("s5_post_fv", fv_b, 0);

    // 6: SETTLE=2, mux output changes within each dwell; capture the cnt=2 value
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    for (int k = 0; k < 16; k++) begin
      mux_c = ((k % 4) < 2) ? early_c[k / 4] : late_c[k / 4];
      chk("s6_sel", {30'd0, s1_c, s0_c}, k / 4);
      chk("s6_sv", sv_c, (k % 4) == 3);
      if ((k % 4) == 3) begin
        chk("s6_sch", sc_c, k / 4);
        chk("s6_sbit", sb_c, late_c[k / 4]);
      end
      tick;
    end
    chk("s6_fv", fv_c, 1);
    chk("s6_frame", fr_c, 4'b0110);
    chk("s6_busy", busy_c, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
